sync_ram_host_ctrl: RTL
=======================

Name: sync_ram_host_ctrl

Overview:
- Host-side initiator for the team's single-port synchronous RAM (DATA_WIDTH x DEPTH, one combined address, 1-cycle registered read, active-low synchronous memory clear).
- Accepts read/write requests on a valid/ready channel and drives the RAM port from registers.
- Tracks the RAM's read latency and returns read data, in order, on a valid/ready response channel backed by a credit-checked response FIFO.

Parameters:
- DATA_WIDTH, 4, RAM word width
- ADDR_WIDTH, 2, RAM address width (RAM DEPTH = 2**ADDR_WIDTH)
- RSP_DEPTH, 4, response FIFO entries; 4 is the minimum for one read per cycle

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  host request valid
- req_ready  out  1  controller accepts the request this cycle
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  request address
- req_wdata  in  DATA_WIDTH  write data (ignored for reads)
- rsp_valid  out  1  read response valid
- rsp_ready  in  1  host accepts the response
- rsp_rdata  out  DATA_WIDTH  read data
- ram_rst_n  out  1  to RAM rst_n, registered, equals ~rst delayed by 1 cycle
- ram_wr_en  out  1  to RAM wr_en
- ram_addr  out  ADDR_WIDTH  to RAM addr_i
- ram_wr_data  out  DATA_WIDTH  to RAM wr_data
- ram_rd_data  in  DATA_WIDTH  from RAM rd_data

Behaviour:
- Reset (rst=1 at a clock edge) clears the following:
  - ram_rst_n, ram_wr_en, ram_addr, ram_wr_data, rsp_valid, rsp_rdata all 0, req_ready 0.
  - Pipeline flags, the outstanding counter and the FIFO pointers all 0.
- rst must be held for at least 2 cycles so the RAM sees rst_n low at an edge. After reset every RAM word reads 0.
- Handshake:
  - A request is accepted when req_valid && req_ready at an edge.
  - Payload must be held stable while req_valid=1 and req_ready=0.
  - rsp_valid, once high, stays high with stable rsp_rdata until rsp_ready=1.
- req_ready = !rst_q && (outstanding < RSP_DEPTH).
  - Registered-state function only; no combinational path from rsp_ready or req_valid.
  - Applies to writes as well.
- outstanding counts accepted reads not yet popped from the FIFO.
  - +1 on read accept, -1 on response pop; both in the same cycle leaves it unchanged.
  - Width $clog2(RSP_DEPTH+1).
- Stage 1 (edge ending accept cycle A):
  - ram_wr_en <= accepted && req_we; ram_addr <= req_addr; ram_wr_data <= req_wdata; s1_rd <= accepted && !req_we.
  - With no accept: ram_wr_en <= 0, ram_addr/ram_wr_data hold.
- Stage 2: cycle A+1, the RAM samples ram_addr; s2_rd <= s1_rd.
- Cycle A+2: if s2_rd, ram_rd_data is pushed into the FIFO at the edge ending A+2.
- Cycle A+3: rsp_valid=1 at the earliest. Read latency is 3 cycles from accept to rsp_valid.
- Writes produce no response. A write is visible to any read accepted in a later cycle.
  - Ops are serialized one per cycle, so the RAM never sees a same-edge read/write conflict.
- FIFO:
  - rsp_valid = !empty; rsp_rdata = head entry; pointers wrap modulo RSP_DEPTH.
  - Push and pop in the same cycle are both legal, including when the FIFO is full.
  - Overflow is impossible by credit; the bench asserts this.
- Throughput: with rsp_ready=1 constantly and RSP_DEPTH=4, one request per cycle is sustained indefinitely.
- Back-pressure: req_ready drops exactly when outstanding reaches RSP_DEPTH. It rises the cycle after a pop.
- Reset mid-operation: in-flight reads and FIFO contents are discarded; no stale response appears after reset deasserts. Any write in stage 1 at the reset edge is dropped (ram_wr_en forced 0).

Test Plan:
- Reset 2 cycles, then read addr 0..3 -> four responses of 0x0, in order, first rsp_valid exactly 3 cycles after the first accept.
- Write 0xA@1, 0x5@2, 0xF@3 back-to-back, then read 3,1,2 -> rsp_rdata sequence 0xF, 0xA, 0x5.
- 16 consecutive reads, rsp_ready=1 always, RSP_DEPTH=4 -> req_ready never drops; 16 responses on 16 consecutive cycles.
- rsp_ready=0 while issuing 6 reads -> exactly 4 accepted, then req_ready=0. rsp_valid held with rsp_rdata stable. After rsp_ready=1, all 6 responses arrive in order, none lost or duplicated.
- Write 0x7@2 and immediately read 2 in the next cycle -> response 0x7 (no stale 0x0).
- Issue 3 reads, assert rst 2 cycles while responses are pending -> rsp_valid=0 from the cycle after the first reset edge, no responses after release. A subsequent read of a previously written address returns 0x0.

Source files
------------

// File: rtl/sync_ram_host_ctrl.sv
// sync_ram_host_ctrl
//   Host-side initiator for a single-port synchronous RAM with a 1-cycle
//   registered read and an active-low synchronous clear. Requests arrive on a
//   valid/ready channel and are replayed onto the RAM port from registers.
//   Read data is returned in order through a small response FIFO. A credit
//   counter guarantees that this FIFO never overflows.
//
// Ports
//   clk, rst        : rising-edge clock, synchronous active-high reset
//   req_valid/ready : request handshake; req_we selects write(1)/read(0)
//   req_addr/wdata  : request address and write data
//   rsp_valid/ready : response handshake; rsp_rdata is the head FIFO entry
//   ram_rst_n       : RAM clear, registered copy of ~rst
//   ram_wr_en/addr/wr_data : registered RAM command
//   ram_rd_data     : RAM registered read data
module sync_ram_host_ctrl #(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned ADDR_WIDTH = 2,
  parameter int unsigned RSP_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  ram_rst_n,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  input  logic [DATA_WIDTH-1:0] ram_rd_data
);

  localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int unsigned PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

  logic                  rst_q;
  logic                  s1_rd;
  logic                  s2_rd;
  logic [CNT_W-1:0]      outstanding;
  logic [CNT_W-1:0]      fifo_count;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [DATA_WIDTH-1:0] fifo_mem [RSP_DEPTH];

  logic accept;
  logic rd_accept;
  logic push;
  logic pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // req_ready depends only on registered state. Every accepted read owns a
  // FIFO slot from acceptance until it is popped, so the FIFO cannot overflow.
  always_comb begin
    req_ready = !rst_q && (outstanding < CNT_W'(RSP_DEPTH));
    accept    = req_valid && req_ready;
    rd_accept = accept && !req_we;
    rsp_valid = (fifo_count != '0);
    rsp_rdata = rsp_valid ? fifo_mem[rd_ptr] : '0;
    push      = s2_rd;
    pop       = rsp_valid && rsp_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rst_q       <= 1'b1;
      ram_rst_n   <= 1'b0;
      ram_wr_en   <= 1'b0;
      ram_addr    <= '0;
      ram_wr_data <= '0;
      s1_rd       <= 1'b0;
      s2_rd       <= 1'b0;
      outstanding <= '0;
      fifo_count  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      rst_q     <= 1'b0;
      ram_rst_n <= 1'b1;

      // Stage 1: present the command to the RAM; address/data hold when idle.
      ram_wr_en <= accept && req_we;
      if (accept) begin
        ram_addr    <= req_addr;
        ram_wr_data <= req_wdata;
      end
      s1_rd <= rd_accept;
      // Stage 2: RAM samples ram_addr; its data is valid one cycle later.
      s2_rd <= s1_rd;

      case ({rd_accept, pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase

      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase

      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
    end
  end

  // FIFO storage is left unreset; stale entries are never visible because
  // rsp_rdata is gated by rsp_valid.
  always_ff @(posedge clk) begin
    if (!rst && push) fifo_mem[wr_ptr] <= ram_rd_data;
  end

endmodule
